// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port indices, FSM state encoding and the latched request header.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NPORT  = 2;

    localparam logic P_CORE = 1'b0;
    localparam logic P_AUX  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } req_hdr_t;

    // One-hot port vector for a port index.
    function automatic logic [NPORT-1:0] port_onehot(logic id);
        return (id == P_AUX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the core/aux masters and the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned N = 32
);

    logic [NPORT-1:0]  req_valid;
    logic [NPORT-1:0]  req_ready;
    logic [NPORT-1:0]  req_we;
    logic [NPORT-1:0]  req_lock;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [N-1:0]      req_wdata0;
    logic [N-1:0]      req_wdata1;
    logic [NPORT-1:0]  rsp_valid;
    logic              rsp_err;
    logic [N-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: masked ports are ineligible; on a tie the port
// that did not win last time is granted.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NPORT-1:0] valid,
    input  logic             last,
    input  logic [NPORT-1:0] mask,
    output logic [NPORT-1:0] grant_c
);

    logic [NPORT-1:0] elig_c;

    always_comb begin
        elig_c  = valid & ~mask;
        grant_c = elig_c;
        if (elig_c == 2'b11) begin
            grant_c = port_onehot(!last);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (IDLE -> ACCESS -> RESP).
// Optional bus locking is built only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [N-1:0]      mem_write_data,
    input  logic [N-1:0]      mem_read_data
);

    state_t           state_q, state_d;
    req_hdr_t         hdr_q;
    req_hdr_t         sel_hdr_c;
    logic [N-1:0]     sel_wdata_c;
    logic             id_q, last_q;
    logic [NPORT-1:0] mask_c, gnt_c;
    logic             can_accept_c, xfer_c, sel_c;
    logic             sel_in_range_c, hdr_in_range_c;

    rr_arb2 u_rr (
        .valid   (bus.req_valid),
        .last    (last_q),
        .mask    (mask_c),
        .grant_c (gnt_c)
    );

    assign can_accept_c  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign bus.req_ready = can_accept_c ? gnt_c : '0;
    assign xfer_c        = can_accept_c && (gnt_c != '0);
    assign sel_c         = gnt_c[P_AUX];

    // Payload of the port being granted this cycle.
    always_comb begin
        sel_hdr_c.we   = bus.req_we[sel_c];
        sel_hdr_c.addr = (sel_c == P_AUX) ? bus.req_addr1 : bus.req_addr0;
        sel_wdata_c    = (sel_c == P_AUX) ? bus.req_wdata1 : bus.req_wdata0;
    end

    assign sel_in_range_c = sel_hdr_c.addr < ADDR_W'(DEPTH);
    assign hdr_in_range_c = hdr_q.addr < ADDR_W'(DEPTH);
    assign mem_address    = hdr_q.addr;

`ifdef DMEM_ARB_LOCK_EN
    logic own_v_q, own_id_q, lock_q;

    assign mask_c = own_v_q ? port_onehot(!own_id_q) : '0;

    // Ownership is released as the owner's unlocked transfer leaves ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_v_q  <= 1'b0;
            own_id_q <= P_CORE;
            lock_q   <= 1'b0;
        end else begin
            if (xfer_c) begin
                lock_q <= bus.req_lock[sel_c];
            end
            if ((state_q == ST_ACCESS) && !lock_q && own_v_q && (own_id_q == id_q)) begin
                own_v_q <= 1'b0;
            end
            if (xfer_c && bus.req_lock[sel_c]) begin
                own_v_q  <= 1'b1;
                own_id_q <= sel_c;
            end
        end
    end
`else
    logic unused_lock_c;

    assign mask_c        = '0;
    assign unused_lock_c = ^bus.req_lock;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (xfer_c) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = xfer_c ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered at accept so they are high for exactly the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q         <= P_AUX;
            id_q           <= P_CORE;
            hdr_q          <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            bus.rsp_valid  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_rdata  <= '0;
        end else begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            if (xfer_c) begin
                id_q           <= sel_c;
                last_q         <= sel_c;
                hdr_q          <= sel_hdr_c;
                mem_write_data <= sel_wdata_c;
                mem_write      <= sel_hdr_c.we && sel_in_range_c;
                mem_read       <= !sel_hdr_c.we && sel_in_range_c;
            end
            if (state_q == ST_ACCESS) begin
                bus.rsp_valid <= port_onehot(id_q);
                bus.rsp_err   <= !hdr_in_range_c;
                bus.rsp_rdata <= (!hdr_q.we && hdr_in_range_c) ? mem_read_data : '0;
            end
        end
    end

endmodule
